// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scalar register bank and its busy scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 3;
    localparam int ZERO_REG_IDX = 0;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a load reservation sets a bit, the load return clears it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rsv_en,
    input  logic [$clog2(DEPTH)-1:0] rsv_addr,
    input  logic                     clr_en,
    input  logic [$clog2(DEPTH)-1:0] clr_addr,
    output logic [DEPTH-1:0]         busy
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // A reservation wins over a same-cycle clear so a re-issued load stays tracked.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr_en && (clr_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_REG_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/scalar_regbank.sv
// Multi-read, dual-write scalar register file with write-to-read bypass,
// optional hardwired zero register and load-busy scoreboard.
module scalar_regbank
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [2**ADDR_W-1:0]     busy,
    output logic                     wr_collide
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_collide_q;
    logic              wr_collide_d;

    // Port 1 is applied first so a same-address port 0 write overrides it.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (wr1_en && (wr1_addr == ADDR_W'(r))) begin
                regs_d[r] = wr1_data;
            end
            if (wr0_en && (wr0_addr == ADDR_W'(r))) begin
                regs_d[r] = wr0_data;
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[ZERO_REG_IDX] = '0;
        end
        wr_collide_d = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            wr_collide_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            wr_collide_q <= wr_collide_d;
        end
    end

    assign wr_collide = wr_collide_q;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_en   (wr1_en),
        .clr_addr (wr1_addr),
        .busy     (busy)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

        // Zero register and reset both override any bypassed value.
        always_comb begin
            data = regs_q[ra];
            if ((BYPASS != 0) && wr1_en && (wr1_addr == ra)) begin
                data = wr1_data;
            end
            if ((BYPASS != 0) && wr0_en && (wr0_addr == ra)) begin
                data = wr0_data;
            end
            if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_REG_IDX))) begin
                data = '0;
            end
            if (!rst_n) begin
                data = '0;
            end
        end

        always_comb begin
            bsy = busy[ra];
            if ((BYPASS != 0) && wr1_en && (wr1_addr == ra) &&
                !(rsv_en && (rsv_addr == ra))) begin
                bsy = 1'b0;
            end
            if (!rst_n) begin
                bsy = 1'b0;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data;
        assign rd_busy[gi]                  = bsy;
    end

endmodule

// File: tb/tb_scalar_regbank.sv
// Directed bench for scalar_regbank: default build plus a ZERO_REG=1 build sharing stimulus.
module tb_scalar_regbank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data, rd_data_z;
    logic [1:0]  rd_busy, rd_busy_z;
    logic        wr0_en = 1'b0;
    logic [2:0]  wr0_addr = '0;
    logic [15:0] wr0_data = '0;
    logic        wr1_en = 1'b0;
    logic [2:0]  wr1_addr = '0;
    logic [15:0] wr1_data = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic [7:0]  busy, busy_z;
    logic        wr_collide, wr_collide_z;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    scalar_regbank #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy), .wr_collide(wr_collide)
    );

    scalar_regbank #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_z), .wr_collide(wr_collide_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (rd_data !== 32'h0 || busy !== 8'h0 || wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: rd_data=%h busy=%h collide=%b, need 0/0/0", rd_data, busy, wr_collide);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hBEEF;
        rsv_en = 1'b1; rsv_addr = 3'd1;
        tick();
        idle();
        rd_addr[2:0] = 3'd3;
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'hBEEF || busy !== 8'h02) begin
            errors++;
            $display("FAIL reset_prewrite: r3=%h busy=%h, need beef/02", rd_data[15:0], busy);
        end
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'h1111;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'h0 || busy !== 8'h0 || wr_collide !== 1'b0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: r3=%h busy=%h collide=%b rd_busy=%b, need 0", rd_data[15:0], busy, wr_collide, rd_busy);
        end
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'h0) begin
            errors++;
            $display("FAIL reset_no_write: r3=%h, need 0000", rd_data[15:0]);
        end
        $display("reset: done");
    endtask

    task automatic test_bypass();
        tick();
        rd_addr = {3'd7, 3'd5};
        wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 16'h1234;
        wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 16'h7777;
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_wr0: got %h, need 1234", rd_data[15:0]);
        end
        vectors++;
        if (rd_data[31:16] !== 16'h7777) begin
            errors++;
            $display("FAIL bypass_wr1: got %h, need 7777", rd_data[31:16]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data !== {16'h7777, 16'h1234}) begin
            errors++;
            $display("FAIL bypass_stored: got %h, need 77771234", rd_data);
        end
        $display("bypass: r5/r7 written");
    endtask

    task automatic test_collision();
        tick();
        rd_addr = {3'd1, 3'd2};
        wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'hAAAA;
        wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h5555;
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL collide_bypass: got %h, need aaaa", rd_data[15:0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data[15:0] !== 16'hAAAA || wr_collide !== 1'b1) begin
            errors++;
            $display("FAIL collide_store: r2=%h collide=%b, need aaaa/1", rd_data[15:0], wr_collide);
        end
        wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h1111;
        wr1_en = 1'b1; wr1_addr = 3'd0; wr1_data = 16'h2222;
        tick();
        idle();
        rd_addr = {3'd1, 3'd0};
        #1;
        vectors++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL collide_pulse: collide=%b, need 0", wr_collide);
        end
        vectors++;
        if (rd_data !== {16'h1111, 16'h2222}) begin
            errors++;
            $display("FAIL dual_write: got %h, need 11112222", rd_data);
        end
        $display("collision: r2 collide, r0/r1 dual write");
    endtask

    task automatic test_scoreboard();
        tick();
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        idle();
        rd_addr = {3'd0, 3'd4};
        #1;
        vectors++;
        if (busy !== 8'h10 || rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserve: busy=%h rd_busy0=%b, need 10/1", busy, rd_busy[0]);
        end
        tick();
        wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 16'h0F0F;
        #1;
        vectors++;
        if (rd_busy[0] !== 1'b0 || busy[4] !== 1'b1 || rd_data[15:0] !== 16'h0F0F) begin
            errors++;
            $display("FAIL sb_clear_bypass: rd_busy0=%b busy4=%b r4=%h, need 0/1/0f0f", rd_busy[0], busy[4], rd_data[15:0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (busy !== 8'h00 || rd_data[15:0] !== 16'h0F0F) begin
            errors++;
            $display("FAIL sb_cleared: busy=%h r4=%h, need 00/0f0f", busy, rd_data[15:0]);
        end
        $display("scoreboard: r4 reserve/clear");
    endtask

    task automatic test_rsv_vs_clear();
        tick();
        rsv_en = 1'b1; rsv_addr = 3'd6;
        tick();
        rd_addr = {3'd6, 3'd0};
        wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 16'hABCD;
        #1;
        vectors++;
        if (busy[6] !== 1'b1 || rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL rvc_pre: busy6=%b rd_busy1=%b, need 1/1", busy[6], rd_busy[1]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (busy[6] !== 1'b1 || rd_data[31:16] !== 16'hABCD) begin
            errors++;
            $display("FAIL rvc_post: busy6=%b r6=%h, need 1/abcd", busy[6], rd_data[31:16]);
        end
        $display("rsv_vs_clear: r6");
    endtask

    task automatic test_zero_reg();
        tick();
        rd_addr = {3'd6, 3'd0};
        wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 3'd0;
        #1;
        vectors++;
        if (rd_data_z[15:0] !== 16'h0 || rd_data[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_bypass: zero=%h plain=%h, need 0000/ffff", rd_data_z[15:0], rd_data[15:0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data_z[15:0] !== 16'h0 || busy_z[0] !== 1'b0 || rd_busy_z[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: r0=%h busy0=%b rd_busy0=%b, need 0/0/0", rd_data_z[15:0], busy_z[0], rd_busy_z[0]);
        end
        vectors++;
        if (rd_data[15:0] !== 16'hFFFF || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL nonzero_r0: r0=%h busy0=%b, need ffff/1", rd_data[15:0], busy[0]);
        end
        $display("zero_reg: r0 write/reserve");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_rsv_vs_clear();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
